// File: rtl/onehot_mux.sv
// One-hot AND-OR multiplexer with a registered output copy, select-vector
// diagnostics and a sticky multi-select error flag.
module onehot_mux #(
    parameter int N_INPUTS = 2,
    parameter int W_INPUT  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_INPUTS*W_INPUT-1:0]   in,
    input  logic [N_INPUTS-1:0]           sel,
    input  logic                          en,
    input  logic                          err_clr,
    output logic [W_INPUT-1:0]            out,
    output logic [W_INPUT-1:0]            out_q,
    output logic                          sel_multi,
    output logic                          sel_none,
    output logic                          err_sticky
);

    logic [W_INPUT-1:0]  mux_s;
    logic [N_INPUTS-1:0] sel_dec_s;
    logic [W_INPUT-1:0]  out_r;
    logic                err_r;

    // AND-OR mux: every selected slot contributes, no priority between slots
    always_comb begin
        mux_s = {W_INPUT{1'b0}};
        for (int i = 0; i < N_INPUTS; i++) begin
            mux_s = mux_s | (in[i*W_INPUT +: W_INPUT] & {W_INPUT{sel[i]}});
        end
    end

    // Clearing the lowest set bit leaves a nonzero value only when two or more bits are set
    always_comb begin
        sel_dec_s = sel & (sel - N_INPUTS'(1));
    end

    assign out       = mux_s;
    assign sel_none  = (sel == {N_INPUTS{1'b0}});
    assign sel_multi = (sel_dec_s != {N_INPUTS{1'b0}});

    // Registered copy of the mux result, captured only when enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r <= {W_INPUT{1'b0}};
        end else if (en) begin
            out_r <= mux_s;
        end else begin
            out_r <= out_r;
        end
    end

    // Sticky error: clear wins over a simultaneous multi-select
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (err_clr) begin
            err_r <= 1'b0;
        end else if (sel_multi) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign out_q      = out_r;
    assign err_sticky = err_r;

endmodule

// File: tb/tb_onehot_mux.sv
// Directed-vector bench for onehot_mux: a 2x32 instance for the full feature
// set and a 3x8 instance for the select walk.
module tb_onehot_mux;

    logic        clk;
    logic        rst;
    logic [63:0] in_a;
    logic [1:0]  sel_a;
    logic        en_a;
    logic        err_clr_a;
    logic [31:0] out_a;
    logic [31:0] out_q_a;
    logic        sel_multi_a;
    logic        sel_none_a;
    logic        err_sticky_a;

    logic [23:0] in_b;
    logic [2:0]  sel_b;
    logic [7:0]  out_b;
    logic [7:0]  out_q_b;
    logic        sel_multi_b;
    logic        sel_none_b;
    logic        err_sticky_b;

    int checks;
    int errors;

    onehot_mux #(.N_INPUTS(2), .W_INPUT(32)) dut_a (
        .clk(clk), .rst(rst), .in(in_a), .sel(sel_a), .en(en_a),
        .err_clr(err_clr_a), .out(out_a), .out_q(out_q_a),
        .sel_multi(sel_multi_a), .sel_none(sel_none_a), .err_sticky(err_sticky_a)
    );

    onehot_mux #(.N_INPUTS(3), .W_INPUT(8)) dut_b (
        .clk(clk), .rst(rst), .in(in_b), .sel(sel_b), .en(1'b0),
        .err_clr(1'b0), .out(out_b), .out_q(out_q_b),
        .sel_multi(sel_multi_b), .sel_none(sel_none_b), .err_sticky(err_sticky_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_a      = {32'hDEADBEEF, 32'h12345678};
        sel_a     = 2'b01;
        en_a      = 1'b1;
        err_clr_a = 1'b0;
        in_b      = {8'hC3, 8'h5A, 8'h0F};
        sel_b     = 3'b000;

        // Reset held across edges: registers stay zero, mux still follows inputs
        #12;
        check_val("rst_out_q", out_q_a, 32'h0);
        check_val("rst_err", {31'h0, err_sticky_a}, 32'h0);
        check_val("rst_out_comb", out_a, 32'h12345678);

        @(negedge clk);
        rst  = 1'b0;
        en_a = 1'b0;

        // Combinational mux
        sel_a = 2'b01; #1;
        check_val("sel01_out", out_a, 32'h12345678);
        check_val("sel01_none", {31'h0, sel_none_a}, 32'h0);
        check_val("sel01_multi", {31'h0, sel_multi_a}, 32'h0);
        sel_a = 2'b10; #1;
        check_val("sel10_out", out_a, 32'hDEADBEEF);
        check_val("sel10_none", {31'h0, sel_none_a}, 32'h0);
        check_val("sel10_multi", {31'h0, sel_multi_a}, 32'h0);
        sel_a = 2'b00; #1;
        check_val("sel00_out", out_a, 32'h0);
        check_val("sel00_none", {31'h0, sel_none_a}, 32'h1);
        check_val("sel00_multi", {31'h0, sel_multi_a}, 32'h0);
        sel_a = 2'b11; #1;
        check_val("sel11_out", out_a, 32'hDEBDFEFF);
        check_val("sel11_multi", {31'h0, sel_multi_a}, 32'h1);
        check_val("sel11_none", {31'h0, sel_none_a}, 32'h0);

        // Registered path and hold
        sel_a = 2'b10;
        en_a  = 1'b1;
        @(negedge clk);
        check_val("capture_out_q", out_q_a, 32'hDEADBEEF);
        en_a = 1'b0;
        in_a = {32'h0, 32'h12345678};
        #1;
        check_val("hold_out_comb", out_a, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val($sformatf("hold_out_q_%0d", k), out_q_a, 32'hDEADBEEF);
            check_val($sformatf("hold_out_%0d", k), out_a, 32'h0);
        end
        in_a = {32'hDEADBEEF, 32'h12345678};

        // Sticky error, updated while en=0
        sel_a = 2'b11;
        @(negedge clk);
        check_val("err_set", {31'h0, err_sticky_a}, 32'h1);
        check_val("err_set_out_q_held", out_q_a, 32'hDEADBEEF);
        sel_a = 2'b01;
        @(negedge clk);
        check_val("err_hold", {31'h0, err_sticky_a}, 32'h1);
        err_clr_a = 1'b1;
        @(negedge clk);
        check_val("err_clr", {31'h0, err_sticky_a}, 32'h0);
        sel_a = 2'b11;
        @(negedge clk);
        check_val("err_clr_prio", {31'h0, err_sticky_a}, 32'h0);
        err_clr_a = 1'b0;

        // Async reset between edges
        @(negedge clk);
        check_val("err_set_again", {31'h0, err_sticky_a}, 32'h1);
        sel_a = 2'b10;
        en_a  = 1'b1;
        @(negedge clk);
        check_val("pre_rst_out_q", out_q_a, 32'hDEADBEEF);
        check_val("pre_rst_err", {31'h0, err_sticky_a}, 32'h1);
        #1 rst = 1'b1;
        #1;
        check_val("async_rst_out_q", out_q_a, 32'h0);
        check_val("async_rst_err", {31'h0, err_sticky_a}, 32'h0);
        check_val("async_rst_out_comb", out_a, 32'hDEADBEEF);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_capture", out_q_a, 32'hDEADBEEF);
        check_val("post_rst_err", {31'h0, err_sticky_a}, 32'h0);

        // Three-slot walk
        sel_b = 3'b001; #1;
        check_val("n3_sel001", {24'h0, out_b}, 32'h0F);
        sel_b = 3'b010; #1;
        check_val("n3_sel010", {24'h0, out_b}, 32'h5A);
        sel_b = 3'b100; #1;
        check_val("n3_sel100", {24'h0, out_b}, 32'hC3);
        check_val("n3_multi_single", {31'h0, sel_multi_b}, 32'h0);
        sel_b = 3'b101; #1;
        check_val("n3_sel101", {24'h0, out_b}, 32'hCF);
        check_val("n3_multi", {31'h0, sel_multi_b}, 32'h1);
        sel_b = 3'b000; #1;
        check_val("n3_none", {31'h0, sel_none_b}, 32'h1);
        check_val("n3_none_out", {24'h0, out_b}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/onehot_mux.md
ONEHOT_MUX -- requirements
Module: onehot_mux

Interface
REQ-001 The block SHALL have parameter N_INPUTS, default 2, number of input slots; legal range 1..32.
REQ-002 The block SHALL have parameter W_INPUT, default 32, width of each slot and of the outputs; legal range >= 1.
REQ-003 Port clk  input  1  sole clock; all sequential logic is rising-edge triggered.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port in  input  N_INPUTS*W_INPUT  packed slots; slot i occupies bits [i*W_INPUT +: W_INPUT].
REQ-006 Port sel  input  N_INPUTS  select vector, intended one-hot; bit i selects slot i.
REQ-007 Port en  input  1  capture enable for the registered output.
REQ-008 Port err_clr  input  1  synchronous clear of the sticky error flag.
REQ-009 Port out  output  W_INPUT  combinational mux result.
REQ-010 Port out_q  output  W_INPUT  registered copy of out.
REQ-011 Port sel_multi  output  1  combinational; more than one sel bit is set.
REQ-012 Port sel_none  output  1  combinational; no sel bit is set.
REQ-013 Port err_sticky  output  1  registered; latched sel_multi.

Function
REQ-014 out SHALL equal the bitwise OR over all i of (slot i AND replicated sel[i]), with zero clock latency.
REQ-015 When sel has exactly one bit i set, out SHALL equal slot i exactly.
REQ-016 When sel is all zeros, out SHALL be all zeros.
REQ-017 When several sel bits are set, out SHALL be the bitwise OR of all selected slots; no priority encoding is permitted.
REQ-018 The out path SHALL contain no latches and SHALL have no dependency on clk or rst.
REQ-019 sel_none SHALL be 1 iff sel == 0.
REQ-020 sel_multi SHALL be 1 iff popcount(sel) >= 2.
REQ-021 With N_INPUTS == 1, sel_multi SHALL be constant 0, and out SHALL equal in when sel[0]=1, otherwise 0.
REQ-022 On each rising clk edge with en=1, out_q SHALL load the current value of out.
REQ-023 On each rising clk edge with en=0, out_q SHALL hold its value.
REQ-024 On each rising clk edge, err_sticky SHALL be updated as follows:
- err_clr=1: err_sticky clears to 0. Clear has priority over a simultaneous set.
- otherwise, sel_multi=1: err_sticky sets to 1.
- otherwise: err_sticky holds.
REQ-025 err_sticky SHALL be updated regardless of the value of en.
REQ-026 A change of in or sel SHALL reach out within the same cycle.
REQ-027 A change of in or sel SHALL reach out_q exactly one clock edge later, and only if en=1 at that edge.

Reset
REQ-028 While rst=1, out_q SHALL be 0 and err_sticky SHALL be 0, asserted immediately without waiting for a clk edge.
REQ-029 Deassertion of rst SHALL be honoured at the next rising edge; the first capture SHALL occur at the first edge with rst=0 and en=1.
REQ-030 The combinational outputs out, sel_multi and sel_none SHALL follow their inputs during reset.
REQ-031 Reset asserted mid-operation SHALL discard the held out_q value and any latched error.

Verification
REQ-032 N=2, W=32, in={slot1=0xDEADBEEF, slot0=0x12345678}:
- sel=2'b01 -> out=0x12345678.
- sel=2'b10 -> out=0xDEADBEEF.
- sel_none=0 and sel_multi=0 in both cases.
REQ-033 Same in, sel=2'b00 -> out=0, sel_none=1, sel_multi=0. Then sel=2'b11 -> out=0xDEBDFEFF (OR of both slots), sel_multi=1.
REQ-034 Registered path with sel=2'b10 and en=1: after one edge out_q=0xDEADBEEF. Then set en=0 and change slot1 to 0x0: out_q stays 0xDEADBEEF across 3 edges while out=0.
REQ-035 Sticky error:
- sel=2'b11 for one edge -> err_sticky=1.
- Return to sel=2'b01 -> err_sticky remains 1.
- err_clr=1 for one edge -> err_sticky=0.
- err_clr=1 with sel=2'b11 at the same edge -> err_sticky=0.
REQ-036 Asynchronous reset: with out_q=0xDEADBEEF and err_sticky=1, pulse rst between clock edges -> both read 0 immediately, before the next edge.
REQ-037 N=3, W=8, in={0xC3, 0x5A, 0x0F}: walk sel through 001, 010, 100 -> out=0x0F, 0x5A, 0xC3.
